// File: rtl/inbox_fifo.sv
// -----------------------------------------------------------------------------
// inbox_fifo
// -----------------------------------------------------------------------------
// Purpose:
//   Single-clock show-ahead FIFO. The head word is always visible on `data`
//   while the FIFO holds at least one word, and reads as all-zero when it is
//   empty. Occupancy flags are decoded from a registered word counter only,
//   so they have no combinational path from the strobes. Two sticky error
//   flags record a read while empty (underflow) and a write dropped because
//   the FIFO was full (overflow).
//
// Parameters:
//   DATA_W   - word width in bits
//   DEPTH    - storage depth in words (power of two, >= 2)
//   AF_LEVEL - count at or above which almost_full asserts
//
// Ports:
//   clk         in   single clock, all state updates on posedge
//   rst         in   synchronous active-high reset
//   wIn         in   write strobe
//   wData       in   write word [DATA_W]
//   rIn         in   read strobe, pops the head word
//   clrErr      in   clear the sticky error flags
//   data        out  head word (show-ahead), zero when empty [DATA_W]
//   empty       out  count == 0
//   full        out  count == DEPTH
//   almost_full out  count >= AF_LEVEL
//   count       out  words held, 0..DEPTH [AW+1]
//   errUnder    out  sticky: read attempted while empty
//   errOver     out  sticky: write dropped while full
// -----------------------------------------------------------------------------
module inbox_fifo #(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wIn,
    input  logic [DATA_W-1:0]            wData,
    input  logic                         rIn,
    input  logic                         clrErr,
    output logic [DATA_W-1:0]            data,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         errUnder,
    output logic                         errOver
);

    localparam int AW = $clog2(DEPTH);

    // Counter-width copies of the thresholds, so the flag compares are
    // same-width unsigned compares.
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_CNT    = AF_LEVEL[AW:0];
    localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_ZERO  = {(AW+1){1'b0}};

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Pointer advance; AW-bit arithmetic wraps DEPTH-1 -> 0 because DEPTH is
    // a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        ptr_inc = ptr + {{(AW-1){1'b0}}, 1'b1};
    endfunction

    // Sticky flag update: a new event beats a clear in the same cycle.
    function automatic logic sticky_next(input logic cur,
                                         input logic set_ev,
                                         input logic clr);
        if (set_ev) begin
            sticky_next = 1'b1;
        end else if (clr) begin
            sticky_next = 1'b0;
        end else begin
            sticky_next = cur;
        end
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_count;
    logic              r_err_under;
    logic              r_err_over;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic              w_empty;
    logic              w_full;
    logic              w_almost_full;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_under_ev;
    logic              w_over_ev;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW:0]       w_count_nxt;
    logic              w_err_under_nxt;
    logic              w_err_over_nxt;
    logic [DATA_W-1:0] w_head;

    // Occupancy flags come from the registered counter only.
    always_comb begin
        w_empty       = (r_count == CNT_ZERO);
        w_full        = (r_count == DEPTH_CNT);
        w_almost_full = (r_count >= AF_CNT);
    end

    // Accept/reject decisions and error events for this cycle.
    always_comb begin
        // A full FIFO still takes a write when a read frees a slot on the
        // same edge; an empty FIFO never honours a read, even alongside a
        // write, because the incoming word is not yet readable.
        w_wr_en    = wIn & (~w_full | rIn);
        w_rd_en    = rIn & ~w_empty;
        w_under_ev = rIn & w_empty;
        w_over_ev  = wIn & w_full & ~rIn;
    end

    // Next-state values for pointers, counter and sticky flags.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;

        if (w_wr_en) begin
            w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_rd_en) begin
            w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            2'b11:   w_count_nxt = r_count;
            2'b00:   w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase

        w_err_under_nxt = sticky_next(r_err_under, w_under_ev, clrErr);
        w_err_over_nxt  = sticky_next(r_err_over,  w_over_ev,  clrErr);
    end

    // Show-ahead head word; forced to zero when empty so stale memory
    // (including words discarded by a reset) never leaks out.
    always_comb begin
        if (w_empty) begin
            w_head = {DATA_W{1'b0}};
        end else begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------

    // Storage array: written on accepted writes, intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= wData;
        end
    end

    // Pointers and word counter; reset wins over every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Sticky error flags; reset wins over clrErr and new events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_under <= 1'b0;
            r_err_over  <= 1'b0;
        end else begin
            r_err_under <= w_err_under_nxt;
            r_err_over  <= w_err_over_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    // Drive the output ports.
    always_comb begin
        data        = w_head;
        empty       = w_empty;
        full        = w_full;
        almost_full = w_almost_full;
        count       = r_count;
        errUnder    = r_err_under;
        errOver     = r_err_over;
    end

endmodule

// File: doc/inbox_fifo.md
INBOX_FIFO -- requirements
Module: inbox_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning storage depth in words, a power of two and at least 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL derive localparam AW = clog2(DEPTH), meaning pointer width.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its posedge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-007 The block SHALL have port wIn, input, 1 bit, meaning write strobe.
REQ-008 The block SHALL have port wData, input, DATA_W bits, meaning write word.
REQ-009 The block SHALL have port rIn, input, 1 bit, meaning read strobe; pops the head word.
REQ-010 The block SHALL have port clrErr, input, 1 bit, meaning clear sticky error flags.
REQ-011 The block SHALL have port data, output, DATA_W bits, meaning the current head word (show-ahead).
REQ-012 The block SHALL have port empty, output, 1 bit, meaning count == 0.
REQ-013 The block SHALL have port full, output, 1 bit, meaning count == DEPTH.
REQ-014 The block SHALL have port almost_full, output, 1 bit, meaning count >= AF_LEVEL.
REQ-015 The block SHALL have port count, output, AW+1 bits, meaning words held, range 0..DEPTH.
REQ-016 The block SHALL have port errUnder, output, 1 bit, meaning sticky flag for a read while empty.
REQ-017 The block SHALL have port errOver, output, 1 bit, meaning sticky flag for a dropped write.

Function
REQ-018 The block SHALL implement storage as a DEPTH x DATA_W array with read pointer rd_ptr and write pointer wr_ptr, both AW bits and wrapping modulo DEPTH.
REQ-019 The block SHALL accept a write when wIn=1 and (full=0 or rIn=1): mem[wr_ptr] <= wData, wr_ptr+1.
REQ-020 The block SHALL accept a read when rIn=1 and empty=0: rd_ptr+1.
REQ-021 The block SHALL update count per cycle as +1 on write only, -1 on read only, and unchanged on both or neither.
REQ-022 The block SHALL drive data = mem[rd_ptr] combinationally while empty=0 and all-zero while empty=1; a written word SHALL appear on data one cycle after the write edge.
REQ-023 When empty, rIn=1 and wIn=1 occur together, the block SHALL accept the write, ignore the read and set errUnder.
REQ-024 When full, rIn=1 and wIn=1 occur together, the block SHALL accept both; count stays DEPTH, full stays 1 and no error is flagged.
REQ-025 When full, wIn=1 and rIn=0, the block SHALL drop the write, leave mem and pointers unchanged, and set errOver.
REQ-026 When empty, rIn=1 and wIn=0, the block SHALL leave all state unchanged except setting errUnder.
REQ-027 The block SHALL drive empty, full, almost_full and count from registered count only, with no combinational path from wIn or rIn.
REQ-028 The block SHALL keep errUnder and errOver set until clrErr=1 or rst=1; when clrErr coincides with a new error event, set SHALL win.
REQ-029 The block SHALL wrap both pointers from DEPTH-1 to 0 with no data loss across the wrap.

Reset
REQ-030 When rst=1 at a posedge, the block SHALL set rd_ptr=0, wr_ptr=0, count=0, errUnder=0 and errOver=0, giving empty=1, full=0, almost_full=0 and data=0.
REQ-031 The block SHALL give rst priority over wIn, rIn and clrErr in the same cycle; a mid-operation reset discards all stored words.
REQ-032 The block SHALL NOT reset memory contents; the discarded words SHALL never appear on data.

Verification
REQ-033 The bench SHALL run with DATA_W=12, DEPTH=4, AF_LEVEL=3 unless stated otherwise.
REQ-034 Reset then fill: after rst, write 0x001,0x002,0x003,0x004 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full at 4; data=0x001 throughout.
REQ-035 Drain and underflow: from full, assert rIn for 5 cycles -> data shows 0x002,0x003,0x004 then 0 with empty=1; errUnder=1 after the 5th read; pulsing clrErr clears it.
REQ-036 Overflow and full-simultaneous: with the block full, write 0x0AA alone -> dropped, errOver=1, count=4; next cycle rIn+wIn 0x0BB -> count=4 and 0x0BB is the last word out.
REQ-037 Wrap-around: run 10 write/read pairs with values 0x100..0x109 -> every value is read back in order, count never exceeds 1, and no error flag sets.
REQ-038 Empty-simultaneous and reset mid-operation: while empty assert rIn+wIn 0x0CC -> data=0x0CC next cycle, count=1, errUnder=1; then write 0x0DD and assert rst with wIn=1 in the same cycle -> empty=1, count=0, data=0 and both error flags 0.
